ifft_radix2_seq: RTL and testbench

- Sequential in-place radix-2 decimation-in-time inverse FFT; the return path of the forward FFT datapath.
- Captures N complex frequency bins in parallel, computes one butterfly per clock using conjugate twiddles, then presents N time-domain samples in parallel.
- Pairs with the forward butterfly engine for round-trip and equalisation checks.

---
 rtl/ifft_radix2_seq.sv | 224 ++++++++++++++++++++++
 tb/tb_ifft_radix2_seq.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifft_radix2_seq.sv
// Sequential in-place radix-2 DIT inverse FFT: bins loaded bit-reversed, one butterfly per clock, conjugate twiddles.
// Optional macro IFFT_SCALE_EN halves each stage's results (overall 1/N); otherwise every stage only saturates.
module ifft_radix2_seq #(
    parameter int N_POINTS = 16,
    parameter int LOG2_N   = 4,
    parameter int DATA_W   = 16,
    parameter int TW_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [N_POINTS*DATA_W-1:0] in_re,
    input  logic [N_POINTS*DATA_W-1:0] in_im,
    output logic                       busy,
    output logic                       done,
    output logic [N_POINTS*DATA_W-1:0] out_re,
    output logic [N_POINTS*DATA_W-1:0] out_im
);
    localparam int HALF_N = N_POINTS / 2;
    localparam int SW     = $clog2(LOG2_N + 1);
    localparam int BW     = LOG2_N - 1;
    localparam int IW     = LOG2_N - 1;
    localparam int PW     = DATA_W + TW_W + 1;
    localparam int SUMW   = DATA_W + 2;
    localparam int TW_ONE = (1 << (TW_W - 1)) - 1;

    localparam logic [BW-1:0] BFLY_LAST  = BW'(HALF_N - 1);
    localparam logic [SW-1:0] STAGE_LAST = SW'(LOG2_N - 1);
    localparam logic signed [SUMW-1:0] SAT_HI = SUMW'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [SUMW-1:0] SAT_LO = SUMW'(-(1 << (DATA_W - 1)));

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_COMPUTE, ST_DONE} state_t;

    state_t                     state_q, state_d;
    logic [SW-1:0]              stage_q, stage_d;
    logic [BW-1:0]              bfly_q, bfly_d;
    logic signed [DATA_W-1:0]   mem_re_q [N_POINTS];
    logic signed [DATA_W-1:0]   mem_re_d [N_POINTS];
    logic signed [DATA_W-1:0]   mem_im_q [N_POINTS];
    logic signed [DATA_W-1:0]   mem_im_d [N_POINTS];
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic [N_POINTS*DATA_W-1:0] out_re_q, out_re_d;
    logic [N_POINTS*DATA_W-1:0] out_im_q, out_im_d;

    // Taylor series keeps the ROM constants computable at elaboration without math-library calls.
    function automatic int tw_const(input int idx, input bit want_sin);
        real x, term, sum, scaled;
        x = 2.0 * 3.14159265358979323846 * $itor(idx) / $itor(N_POINTS);
        if (want_sin) begin
            term = x;
            sum  = x;
        end else begin
            term = 1.0;
            sum  = 1.0;
        end
        for (int i = 1; i <= 20; i++) begin
            if (want_sin) term = -term * x * x / $itor((2 * i) * (2 * i + 1));
            else          term = -term * x * x / $itor((2 * i - 1) * (2 * i));
            sum = sum + term;
        end
        scaled = sum * $itor(TW_ONE);
        return (scaled >= 0.0) ? $rtoi(scaled + 0.5) : $rtoi(scaled - 0.5);
    endfunction

    function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] k);
        logic [LOG2_N-1:0] r;
        for (int i = 0; i < LOG2_N; i++) r[i] = k[LOG2_N-1-i];
        return r;
    endfunction

    function automatic logic signed [DATA_W-1:0] sat(input logic signed [SUMW-1:0] x);
        if (x > SAT_HI) return DATA_W'(SAT_HI);
        if (x < SAT_LO) return DATA_W'(SAT_LO);
        return DATA_W'(x);
    endfunction

    logic signed [TW_W-1:0] tw_re_rom [HALF_N];
    logic signed [TW_W-1:0] tw_im_rom [HALF_N];

    for (genvar i = 0; i < HALF_N; i++) begin : g_tw
        localparam int TWR = tw_const(i, 1'b0);
        localparam int TWI = tw_const(i, 1'b1);
        assign tw_re_rom[i] = TW_W'(TWR);
        assign tw_im_rom[i] = TW_W'(TWI);
    end

    logic [LOG2_N-1:0]        b_ext, half, kk, grp, addr_a, addr_c;
    logic [IW-1:0]            tw_idx;
    logic signed [DATA_W-1:0] a_re, a_im, c_re, c_im;
    logic signed [TW_W-1:0]   w_re, w_im;
    logic signed [PW-1:0]     prod_re, prod_im;
    logic signed [SUMW-1:0]   t_re, t_im, sum_re, sum_im, dif_re, dif_im;

    always_comb begin
        b_ext  = {1'b0, bfly_q};
        half   = LOG2_N'(1) << stage_q;
        kk     = b_ext & (half - LOG2_N'(1));
        grp    = b_ext >> stage_q;
        addr_a = (grp << (stage_q + SW'(1))) | kk;
        addr_c = addr_a + half;
        tw_idx = IW'(kk << (SW'(LOG2_N - 1) - stage_q));

        a_re = mem_re_q[addr_a];
        a_im = mem_im_q[addr_a];
        c_re = mem_re_q[addr_c];
        c_im = mem_im_q[addr_c];
        w_re = tw_re_rom[tw_idx];
        w_im = tw_im_rom[tw_idx];

        // Full-precision complex product, then truncate the Q.15 fraction of the twiddle.
        prod_re = PW'(c_re) * PW'(w_re) - PW'(c_im) * PW'(w_im);
        prod_im = PW'(c_re) * PW'(w_im) + PW'(c_im) * PW'(w_re);
        t_re    = SUMW'(prod_re >>> (TW_W - 1));
        t_im    = SUMW'(prod_im >>> (TW_W - 1));

        sum_re = SUMW'(a_re) + t_re;
        sum_im = SUMW'(a_im) + t_im;
        dif_re = SUMW'(a_re) - t_re;
        dif_im = SUMW'(a_im) - t_im;
`ifdef IFFT_SCALE_EN
        sum_re = sum_re >>> 1;
        sum_im = sum_im >>> 1;
        dif_re = dif_re >>> 1;
        dif_im = dif_im >>> 1;
`endif
    end

    always_comb begin
        stage_d  = stage_q;
        bfly_d   = bfly_q;
        mem_re_d = mem_re_q;
        mem_im_d = mem_im_q;
        case (state_q)
            ST_LOAD: begin
                stage_d = '0;
                bfly_d  = '0;
                for (int k = 0; k < N_POINTS; k++) begin
                    mem_re_d[bitrev(LOG2_N'(k))] = in_re[DATA_W*k +: DATA_W];
                    mem_im_d[bitrev(LOG2_N'(k))] = in_im[DATA_W*k +: DATA_W];
                end
            end
            ST_COMPUTE: begin
                mem_re_d[addr_a] = sat(sum_re);
                mem_im_d[addr_a] = sat(sum_im);
                mem_re_d[addr_c] = sat(dif_re);
                mem_im_d[addr_c] = sat(dif_im);
                if (bfly_q == BFLY_LAST) begin
                    bfly_d  = '0;
                    stage_d = (stage_q == STAGE_LAST) ? '0 : stage_q + SW'(1);
                end else begin
                    bfly_d = bfly_q + BW'(1);
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = ST_LOAD;
            ST_LOAD:    state_d = ST_COMPUTE;
            ST_COMPUTE: if (bfly_q == BFLY_LAST && stage_q == STAGE_LAST) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Status and result registers trail the state by one clock.
    always_comb begin
        busy_d   = (state_q == ST_LOAD) || (state_q == ST_COMPUTE);
        done_d   = (state_q == ST_DONE);
        out_re_d = out_re_q;
        out_im_d = out_im_q;
        if (state_q == ST_DONE) begin
            for (int k = 0; k < N_POINTS; k++) begin
                out_re_d[DATA_W*k +: DATA_W] = mem_re_q[k];
                out_im_d[DATA_W*k +: DATA_W] = mem_im_q[k];
            end
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            stage_q  <= '0;
            bfly_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            out_re_q <= '0;
            out_im_q <= '0;
            for (int i = 0; i < N_POINTS; i++) begin
                mem_re_q[i] <= '0;
                mem_im_q[i] <= '0;
            end
        end else begin
            stage_q  <= stage_d;
            bfly_q   <= bfly_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            out_re_q <= out_re_d;
            out_im_q <= out_im_d;
            for (int i = 0; i < N_POINTS; i++) begin
                mem_re_q[i] <= mem_re_d[i];
                mem_im_q[i] <= mem_im_d[i];
            end
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign out_re = out_re_q;
    assign out_im = out_im_q;

endmodule

// File: tb/tb_ifft_radix2_seq.sv
// Self-checking bench for ifft_radix2_seq: textbook inverse-FFT model plus hand-computed pins and timing checks.
module tb_ifft_radix2_seq;
    localparam int  N  = 16;
    localparam int  L  = 4;
    localparam int  W  = 16;
    localparam int  TW = 16;
    localparam int  VW = N * W;
    localparam real PI = 3.14159265358979323846;
`ifdef IFFT_SCALE_EN
    localparam int AMP   = 16384;
    localparam int FLAT  = 1024;
    localparam int TOL   = 2;
    localparam int ALLIN = 16384;
`else
    localparam int AMP   = 1000;
    localparam int FLAT  = 1000;
    localparam int TOL   = 3;
    localparam int ALLIN = 30000;
`endif

    logic          clk = 1'b1;
    logic          rst;
    logic          start;
    logic [VW-1:0] in_re, in_im;
    logic          busy, done;
    logic [VW-1:0] out_re, out_im;

    int checks = 0;
    int errors = 0;
    logic [VW-1:0] exp_re_q[$];
    logic [VW-1:0] exp_im_q[$];
    logic [VW-1:0] cmp_er, cmp_ei;

    ifft_radix2_seq #(.N_POINTS(N), .LOG2_N(L), .DATA_W(W), .TW_W(TW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_re(in_re), .in_im(in_im),
        .busy(busy), .done(done), .out_re(out_re), .out_im(out_im)
    );

    always #5 clk = ~clk;

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : $rtoi(x - 0.5);
    endfunction

    function automatic int field(input logic [VW-1:0] v, input int n);
        logic signed [W-1:0] t;
        t = v[W*n +: W];
        return int'(t);
    endfunction

    function automatic int clamp(input longint x);
        if (x > 32767)  return 32767;
        if (x < -32768) return -32768;
        return int'(x);
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic chk_tol(input string name, input int act, input int req, input int tol);
        checks++;
        if (act > req + tol || act < req - tol) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d+/-%0d", name, act, req, tol);
        end
    endtask

    // Inverse FFT from first principles: bit-reversed load, then log2(N) passes of in-place butterflies.
    task automatic model(input logic [VW-1:0] xr, input logic [VW-1:0] xi,
                         output logic [VW-1:0] yr, output logic [VW-1:0] yi);
        int     ar[N];
        int     ai[N];
        int     rev, half, widx;
        longint wr, wi, cr, ci, tr, ti, pr, pi_, qr, qi;
        for (int k = 0; k < N; k++) begin
            rev = 0;
            for (int i = 0; i < L; i++) if (((k >> i) & 1) == 1) rev = rev | (1 << (L - 1 - i));
            ar[rev] = field(xr, k);
            ai[rev] = field(xi, k);
        end
        for (int s = 0; s < L; s++) begin
            half = 1 << s;
            for (int base = 0; base < N; base += 2 * half) begin
                for (int j = 0; j < half; j++) begin
                    widx = j * (N / (2 * half));
                    wr = rnd(32767.0 * $cos(2.0 * PI * widx / N));
                    wi = rnd(32767.0 * $sin(2.0 * PI * widx / N));
                    cr = ar[base + j + half];
                    ci = ai[base + j + half];
                    tr = (cr * wr - ci * wi) >>> 15;
                    ti = (cr * wi + ci * wr) >>> 15;
                    pr  = ar[base + j] + tr;
                    pi_ = ai[base + j] + ti;
                    qr  = ar[base + j] - tr;
                    qi  = ai[base + j] - ti;
`ifdef IFFT_SCALE_EN
                    pr  = pr >>> 1;
                    pi_ = pi_ >>> 1;
                    qr  = qr >>> 1;
                    qi  = qi >>> 1;
`endif
                    ar[base + j]        = clamp(pr);
                    ai[base + j]        = clamp(pi_);
                    ar[base + j + half] = clamp(qr);
                    ai[base + j + half] = clamp(qi);
                end
            end
        end
        for (int n = 0; n < N; n++) begin
            yr[W*n +: W] = W'(ar[n]);
            yi[W*n +: W] = W'(ai[n]);
        end
    endtask

    task automatic expect_xform();
        logic [VW-1:0] yr, yi;
        model(in_re, in_im, yr, yi);
        exp_re_q.push_back(yr);
        exp_im_q.push_back(yi);
    endtask

    task automatic clear_bins();
        in_re = '0;
        in_im = '0;
    endtask

    task automatic set_bin(input int k, input int re, input int im);
        in_re[W*k +: W] = W'(re);
        in_im[W*k +: W] = W'(im);
    endtask

    // Pulses start for one cycle; cycle c is the period after the c-th active edge counted from the sampling edge.
    task automatic run_xform(output int dc, output int bf, output int bc);
        expect_xform();
        dc = -1;
        bf = -1;
        bc = 0;
        @(posedge clk);
        start = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 100 && dc < 0; c++) begin
            @(posedge clk);
            if (c == 0) start = 1'b0;
            if (busy === 1'b1) begin
                if (bf < 0) bf = c;
                bc++;
            end
            if (done === 1'b1) dc = c;
            else @(negedge clk);
        end
    endtask

    always @(posedge clk) begin
        if (rst === 1'b1 && done === 1'b1) begin
            if (exp_re_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done t=%0t actual done=1 required done=0", $time);
            end else begin
                cmp_er = exp_re_q.pop_front();
                cmp_ei = exp_im_q.pop_front();
                for (int n = 0; n < N; n++) begin
                    chk($sformatf("model_re[%0d]", n), field(out_re, n), field(cmp_er, n));
                    chk($sformatf("model_im[%0d]", n), field(out_im, n), field(cmp_ei, n));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int dc, bf, bc, nd, d1, d2, nz;
        rst   = 1'b0;
        start = 1'b0;
        clear_bins();
        repeat (3) @(posedge clk);
        nz = 0;
        for (int n = 0; n < N; n++) if (field(out_re, n) != 0 || field(out_im, n) != 0) nz++;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_out_nonzero", nz, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Single DC bin: every sample equals the flat level, latency and busy window pinned.
        clear_bins();
        set_bin(0, (AMP == 1000) ? 1000 : 16384, 0);
        run_xform(dc, bf, bc);
        chk("done_latency", dc, 34);
        chk("busy_first_cycle", bf, 1);
        chk("busy_cycle_count", bc, 33);
        for (int n = 0; n < N; n++) begin
            chk($sformatf("dc_re[%0d]", n), field(out_re, n), FLAT);
            chk($sformatf("dc_im[%0d]", n), field(out_im, n), 0);
        end

        // Bin 1: a positive-rotating phasor; sample 4 lands on +j.
        clear_bins();
        set_bin(1, AMP, 0);
        run_xform(dc, bf, bc);
        chk("bin1_latency", dc, 34);
        for (int n = 0; n < N; n++) begin
            chk_tol($sformatf("bin1_re[%0d]", n), field(out_re, n), rnd(FLAT * $cos(2.0 * PI * n / N)), TOL);
            chk_tol($sformatf("bin1_im[%0d]", n), field(out_im, n), rnd(FLAT * $sin(2.0 * PI * n / N)), TOL);
        end
        chk_tol("bin1_s4_re", field(out_re, 4), 0, TOL);
        chk_tol("bin1_s4_im", field(out_im, 4), FLAT, TOL);

        // All bins equal: energy concentrates in sample 0.
        clear_bins();
        for (int k = 0; k < N; k++) set_bin(k, ALLIN, 0);
        run_xform(dc, bf, bc);
        chk("flat_latency", dc, 34);
`ifdef IFFT_SCALE_EN
        chk_tol("flat_s0_re", field(out_re, 0), 16384, 8);
        for (int n = 1; n < N; n++) chk_tol($sformatf("flat_re[%0d]", n), field(out_re, n), 0, 8);
`else
        chk("flat_s0_saturated", field(out_re, 0), 32767);
`endif

        // Start held high for 40 cycles: exactly one transform, then one more after IDLE.
        clear_bins();
        set_bin(0, AMP, 0);
        expect_xform();
        expect_xform();
        nd = 0;
        d1 = -1;
        d2 = -1;
        @(posedge clk);
        start = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 110; c++) begin
            @(posedge clk);
            if (c == 39) start = 1'b0;
            if (done === 1'b1) begin
                nd++;
                if (d1 < 0) d1 = c;
                else if (d2 < 0) d2 = c;
            end
            @(negedge clk);
        end
        chk("held_done_count", nd, 2);
        chk("held_first_done", d1, 34);
        chk("held_second_done", d2, 69);

        // Start pulses while busy and while in DONE are ignored.
        expect_xform();
        nd = 0;
        d1 = -1;
        @(posedge clk);
        start = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 90; c++) begin
            @(posedge clk);
            if (c == 0 || c == 11 || c == 34) start = 1'b0;
            if (c == 10 || c == 33) start = 1'b1;
            if (done === 1'b1) begin
                nd++;
                if (d1 < 0) d1 = c;
            end
            @(negedge clk);
        end
        chk("busy_start_done_count", nd, 1);
        chk("busy_start_done_cycle", d1, 34);

        // Asynchronous reset mid-compute aborts with no done.
        clear_bins();
        set_bin(1, AMP, 0);
        expect_xform();
        @(posedge clk);
        start = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            if (c == 0) start = 1'b0;
            if (c < 11) @(negedge clk);
        end
        rst = 1'b0;
        #1;
        exp_re_q.delete();
        exp_im_q.delete();
        nz = 0;
        for (int n = 0; n < N; n++) if (field(out_re, n) != 0 || field(out_im, n) != 0) nz++;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_out_nonzero", nz, 0);
        @(posedge clk);
        rst = 1'b1;
        nd = 0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            if (done === 1'b1) nd++;
        end
        chk("abort_no_done", nd, 0);

        clear_bins();
        set_bin(0, (AMP == 1000) ? 1000 : 16384, 0);
        run_xform(dc, bf, bc);
        chk("post_abort_latency", dc, 34);
        chk("post_abort_s0_re", field(out_re, 0), FLAT);
        chk("post_abort_s15_re", field(out_re, 15), FLAT);

        repeat (3) @(posedge clk);
        chk("pending_expectations", exp_re_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
